// File: rtl/cnt_cmd_sequencer_pkg.sv
// Shared encodings and default sizes for the counter command sequencer.
package cnt_cmd_sequencer_pkg;

    localparam int CNT_W_DEF = 7;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cnt_cmd_sequencer_if.sv
// Valid/ready push bus carrying count requests into the sequencer.
interface cnt_cmd_sequencer_if
    import cnt_cmd_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             i_cmd_valid;
    logic [CNT_W-1:0] i_cmd_num;
    logic             o_cmd_ready;

    modport master (output i_cmd_valid, output i_cmd_num, input  o_cmd_ready);
    modport slave  (input  i_cmd_valid, input  i_cmd_num, output o_cmd_ready);
endinterface

// File: rtl/cnt_cmd_sequencer_fifo.sv
// DEPTH x W synchronous FIFO with flush; head is read combinationally (no bypass).
module cnt_cmd_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [W-1:0]     o_dout,
    output logic [PTR_W:0]   o_level,
    output logic             o_full,
    output logic             o_empty
);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/cnt_cmd_sequencer.sv
// Queues count requests and issues them one at a time to fsm_counter, waiting for done.
module cnt_cmd_sequencer
    import cnt_cmd_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    cnt_cmd_sequencer_if.slave cmd,
    input  logic               i_flush,
    output logic               o_run,
    output logic [CNT_W-1:0]   o_num_cnt,
    input  logic               i_cnt_idle,
    input  logic               i_cnt_done,
    output logic               o_busy,
    output logic [PTR_W:0]     o_level,
    output logic               o_job_done,
    output logic               o_drop
);
    state_t           r_state;
    logic             r_run;
    logic             r_job_done;
    logic             r_drop;
    logic [CNT_W-1:0] r_num_cnt;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_head;

    assign cmd.o_cmd_ready = !w_full;
    assign w_accept = cmd.i_cmd_valid && !w_full;
    // Zero-count requests are acknowledged but never stored.
    assign w_push   = w_accept && (cmd.i_cmd_num != '0);
    assign w_pop    = (r_state == S_IDLE) && !w_empty && i_cnt_idle && !i_flush;

    cnt_cmd_fifo #(
        .W     (CNT_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_din   (cmd.i_cmd_num),
        .i_pop   (w_pop),
        .i_flush (i_flush),
        .o_dout  (w_head),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_job_done <= 1'b0;
            r_drop     <= 1'b0;
            r_num_cnt  <= '0;
        end else begin
            r_run      <= 1'b0;
            r_job_done <= 1'b0;
            r_drop     <= w_accept && (cmd.i_cmd_num == '0);
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state   <= S_ISSUE;
                        r_run     <= 1'b1;
                        r_num_cnt <= w_head;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_cnt_done) begin
                        r_state    <= S_DONE;
                        r_job_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_run      = r_run;
    assign o_num_cnt  = r_num_cnt;
    assign o_job_done = r_job_done;
    assign o_drop     = r_drop;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: doc/cnt_cmd_sequencer.md
Name: cnt_cmd_sequencer

Overview:
- Upstream command stage for fsm_counter.
- Accepts count requests through a valid/ready push interface and buffers them in a small FIFO.
- Issues each request to the counter as a one-cycle o_run pulse with o_num_cnt, then waits for the counter's done before issuing the next.
- Lets software/testbench queue several jobs back-to-back without polling o_idle.

Parameters:
CNT_W, 7, width of count value (matches counter i_num_cnt)
DEPTH, 4, FIFO entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command present
i_cmd_num  input  CNT_W  requested count
o_cmd_ready  output  1  FIFO can accept; equals !full
i_flush  input  1  synchronous clear of queued (not yet issued) commands
o_run  output  1  one-cycle start pulse to counter i_run
o_num_cnt  output  CNT_W  count value to counter i_num_cnt, registered
i_cnt_idle  input  1  counter o_idle
i_cnt_done  input  1  counter o_done
o_busy  output  1  state != S_IDLE
o_level  output  PTR_W+1  FIFO occupancy 0..DEPTH
o_job_done  output  1  one-cycle pulse per completed job
o_drop  output  1  one-cycle pulse when a zero-count command is accepted and discarded

Behaviour:
- Reset (async, reset_n=0): FIFO pointers/level to 0; state S_IDLE; o_run=0, o_num_cnt=0, o_job_done=0, o_drop=0, o_busy=0. o_cmd_ready=1 (FIFO empty).
- Push: occurs when i_cmd_valid && o_cmd_ready at a rising edge.
  - i_cmd_num==0: command is accepted but not stored; o_drop=1 next cycle.
  - Otherwise the value is written at the tail.
- o_cmd_ready is combinational, equal to (level != DEPTH). Push when full is impossible by handshake.
- FSM states: S_IDLE=2'd0, S_ISSUE=2'd1, S_WAIT=2'd2, S_DONE=2'd3.
  - S_IDLE: if level!=0 && i_cnt_idle, go to S_ISSUE. On that same edge: load o_num_cnt from FIFO head and pop the head.
  - S_ISSUE: o_run=1 for exactly this cycle; next state S_WAIT.
  - S_WAIT: on i_cnt_done go to S_DONE; otherwise stay. No timeout.
  - S_DONE: o_job_done=1 for this cycle; next state S_IDLE.
- Latency (empty FIFO, counter idle, not busy): command accepted at edge k → state S_ISSUE and o_run high in the cycle after edge k+1.
  - Minimum gap between o_run pulses is counter runtime + 3 cycles.
- o_num_cnt holds its value from issue until the next issue. It is never changed outside the S_IDLE→S_ISSUE edge.
- Simultaneous push and pop on the same edge: both take effect; level unchanged.
  - Push into an empty FIFO is not visible to the pop decision until the next cycle; no bypass.
- i_flush: on the edge it is sampled high, pointers and level go to 0.
  - Has priority over a same-cycle push (the push is lost, but o_cmd_ready was still high).
  - Has priority over the pop.
  - Does not abort an in-flight job: S_ISSUE/S_WAIT/S_DONE continue normally.
- i_cnt_done outside S_WAIT is ignored.
- If i_cnt_idle is low in S_IDLE, wait; do not pop.
- Reset mid-job clears the queue and state. The counter is expected to be reset by the same reset_n.
- Widths: level counts 0..DEPTH in PTR_W+1 bits; pointers wrap modulo DEPTH naturally.

Decomposition:
- Shared package/header: state encodings S_IDLE..S_DONE, CNT_W default.
- One natural sub-module: cnt_cmd_fifo (DEPTH x CNT_W synchronous FIFO with push, pop, flush, level, full, empty). The FSM lives in cnt_cmd_sequencer.

Test Plan:
- Reset with an outstanding push: assert reset_n=0 mid-cycle → all outputs go to reset values immediately, o_cmd_ready=1, o_level=0.
- Single job: push 100 with counter idle → exactly one o_run pulse with o_num_cnt=100, two cycles after acceptance. After i_cnt_done, one o_job_done pulse; o_busy returns to 0.
- Queue fill: push 5,6,7,8 back-to-back while the counter is held non-idle → o_level=4, o_cmd_ready=0. Release the counter → four o_run pulses in order 5,6,7,8, each only after the prior i_cnt_done.
- Zero count: push 0 → o_drop pulse, o_level unchanged, no o_run.
- Simultaneous push/pop: level=2, push 9 on the pop edge → level stays 2; 9 is issued last.
- Flush mid-job: queue 3 entries and issue the first, then assert i_flush in S_WAIT → o_level=0. The current job still completes with o_job_done; no further o_run.
